// File: rtl/scan_pkg.sv
// Shared types and constants for the scan shift controller.
package scan_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_SHIFT   = 3'd3,
    ST_UNLOAD  = 3'd4,
    ST_FIN     = 3'd5
  } scan_state_e;

  localparam int unsigned MISR_W = 32;
  localparam logic [MISR_W-1:0] MISR_POLY = 32'h0040_0007;

  // One MISR step: shift left, fold the incoming bit into the feedback tap.
  function automatic logic [MISR_W-1:0] misr_step(input logic [MISR_W-1:0] sig,
                                                  input logic              b);
    logic fb;
    fb = sig[MISR_W-1] ^ b;
    return {sig[MISR_W-2:0], 1'b0} ^ (fb ? MISR_POLY : '0);
  endfunction

endpackage

// File: rtl/scan_misr.sv
// 32-bit MISR compacting the response bit stream into a signature.
module scan_misr
  import scan_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_i,
  input  logic              en_i,
  input  logic              bit_i,
  output logic [MISR_W-1:0] sig_o
);

  logic [MISR_W-1:0] sig_q;
  logic [MISR_W-1:0] sig_d;

  always_comb begin
    sig_d = sig_q;
    if (clr_i) begin
      sig_d = '0;
    end else if (en_i) begin
      sig_d = misr_step(sig_q, bit_i);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sig_q <= '0;
    end else begin
      sig_q <= sig_d;
    end
  end

  assign sig_o = sig_q;

endmodule

// File: rtl/scan_shift_ctrl.sv
// Scan chain controller: load/capture/shift/unload sequencing with valid/ready streams.
// Optional response signature compaction when SCAN_MISR_EN is defined.
module scan_shift_ctrl
  import scan_pkg::*;
#(
  parameter int unsigned CHAIN_LEN = 16,
  parameter int unsigned PCNT_W    = 16
) (
  input  logic              CK,
  input  logic              RST,
  input  logic              START,
  input  logic [PCNT_W-1:0] PAT_CNT,
  input  logic              PAT_VALID,
  input  logic              PAT_BIT,
  output logic              PAT_READY,
  output logic              RSP_VALID,
  output logic              RSP_BIT,
  input  logic              RSP_READY,
  output logic              SE,
  output logic              SI,
  input  logic              SO,
  output logic              CKE,
  output logic              BUSY,
  output logic              DONE,
  output logic [31:0]       SIGNATURE
);

  localparam int unsigned BCNT_W = $clog2(CHAIN_LEN + 1);

  scan_state_e       state_q, state_d;
  logic [PCNT_W-1:0] pcnt_q, pcnt_d;
  logic [BCNT_W-1:0] bcnt_q, bcnt_d;
  logic              se_q, busy_q, done_q;

  logic fire;
  logic last_bit;
  logic pat_ready_c, rsp_valid_c, cke_c, si_c;

  assign last_bit = (bcnt_q == BCNT_W'(CHAIN_LEN - 1));

  // Next state, counters and the handshake-driven chain controls.
  always_comb begin
    state_d     = state_q;
    pcnt_d      = pcnt_q;
    bcnt_d      = bcnt_q;
    fire        = 1'b0;
    pat_ready_c = 1'b0;
    rsp_valid_c = 1'b0;
    cke_c       = 1'b0;
    si_c        = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (START) begin
          bcnt_d = '0;
          if (PAT_CNT != '0) begin
            pcnt_d  = PAT_CNT;
            state_d = ST_LOAD;
          end else begin
            state_d = ST_FIN;
          end
        end
      end
      ST_LOAD: begin
        fire        = PAT_VALID;
        pat_ready_c = fire;
        cke_c       = fire;
        si_c        = fire & PAT_BIT;
        if (fire && last_bit) state_d = ST_CAPTURE;
      end
      ST_SHIFT: begin
        // A stimulus bit is only taken when its response slot is free.
        fire        = PAT_VALID & RSP_READY;
        pat_ready_c = fire;
        rsp_valid_c = fire;
        cke_c       = fire;
        si_c        = fire & PAT_BIT;
        if (fire && last_bit) state_d = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        cke_c   = 1'b1;
        pcnt_d  = pcnt_q - PCNT_W'(1);
        state_d = (pcnt_q != PCNT_W'(1)) ? ST_SHIFT : ST_UNLOAD;
      end
      ST_UNLOAD: begin
        fire        = RSP_READY;
        rsp_valid_c = fire;
        cke_c       = fire;
        if (fire && last_bit) state_d = ST_FIN;
      end
      ST_FIN: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (fire) begin
      bcnt_d = last_bit ? '0 : bcnt_q + BCNT_W'(1);
    end
  end

  always_ff @(posedge CK) begin
    if (RST) begin
      state_q <= ST_IDLE;
      pcnt_q  <= '0;
      bcnt_q  <= '0;
      se_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pcnt_q  <= pcnt_d;
      bcnt_q  <= bcnt_d;
      se_q    <= (state_d == ST_LOAD) || (state_d == ST_SHIFT) || (state_d == ST_UNLOAD);
      busy_q  <= (state_d != ST_IDLE);
      done_q  <= (state_d == ST_FIN);
    end
  end

  assign SE        = se_q;
  assign BUSY      = busy_q;
  assign DONE      = done_q;
  assign CKE       = cke_c;
  assign SI        = si_c;
  assign PAT_READY = pat_ready_c;
  assign RSP_VALID = rsp_valid_c;
  assign RSP_BIT   = rsp_valid_c & SO;

`ifdef SCAN_MISR_EN
  logic misr_clr;
  assign misr_clr = (state_q == ST_IDLE) & START;

  scan_misr u_misr (
    .clk   (CK),
    .rst   (RST),
    .clr_i (misr_clr),
    .en_i  (rsp_valid_c),
    .bit_i (RSP_BIT),
    .sig_o (SIGNATURE)
  );
`else
  assign SIGNATURE = '0;
`endif

endmodule

// File: tb/tb_scan_shift_ctrl.sv
// Bench for scan_shift_ctrl: 4-cell inverting-capture chain plus a count-based session model.
module tb_scan_shift_ctrl;

  localparam int CL = 4;

  logic        CK = 1'b0;
  logic        RST, START, PAT_VALID, PAT_BIT, RSP_READY, SO;
  logic [15:0] PAT_CNT;
  logic        PAT_READY, RSP_VALID, RSP_BIT, SE, SI, CKE, BUSY, DONE;
  logic [31:0] SIGNATURE;

  int n_cmp = 0;
  int n_bad = 0;

  scan_shift_ctrl #(.CHAIN_LEN(CL), .PCNT_W(16)) dut (
    .CK(CK), .RST(RST), .START(START), .PAT_CNT(PAT_CNT),
    .PAT_VALID(PAT_VALID), .PAT_BIT(PAT_BIT), .PAT_READY(PAT_READY),
    .RSP_VALID(RSP_VALID), .RSP_BIT(RSP_BIT), .RSP_READY(RSP_READY),
    .SE(SE), .SI(SI), .SO(SO), .CKE(CKE), .BUSY(BUSY), .DONE(DONE),
    .SIGNATURE(SIGNATURE)
  );

  always #5 CK = ~CK;

  // Behavioural chain: shifts SI in at cell 0 when SE, inverts all cells on capture.
  logic [CL-1:0] chain = '0;
  always @(posedge CK) begin
    if (CKE === 1'b1) begin
      if (SE === 1'b1) chain <= {chain[CL-2:0], SI};
      else             chain <= ~chain;
    end
  end
  assign SO = chain[CL-1];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, want, $time);
    end
  endtask

  function automatic logic [31:0] misr_ref(input logic [31:0] s, input logic b);
    logic fb;
    fb = s[31] ^ b;
    return {s[30:0], 1'b0} ^ (fb ? 32'h0040_0007 : 32'h0);
  endfunction

  // Session model: position derived from consumed/produced/capture counts.
  // Each response bit equals the inverse of the stimulus bit with the same index.
  bit          model_en = 0;
  int          m_mode = 0;   // 0 idle, 1 active, 2 fin
  int          m_p, m_c, m_s, m_r;
  bit          stim_q[$];
  logic [31:0] m_sig = '0;

  always @(negedge CK) begin : model
    int   ph;
    logic fire, e_pr, e_rv, e_rb, e_cke, e_si, e_se, e_busy, e_done;
    logic [31:0] e_sig;
    if (model_en) begin
      ph = 0; fire = 0; e_pr = 0; e_rv = 0; e_rb = 0; e_cke = 0; e_si = 0;
      e_se = 0; e_busy = 0; e_done = 0;
      if (m_mode == 1) begin
        e_busy = 1;
        if (m_c < m_p && m_s < CL * (m_c + 1)) ph = 1;
        else if (m_c < m_p)                    ph = 2;
        else                                   ph = 3;
        case (ph)
          1: begin
            fire  = PAT_VALID && (m_c == 0 || RSP_READY);
            e_se  = 1; e_pr = fire; e_cke = fire; e_si = fire & PAT_BIT;
            e_rv  = fire && (m_c > 0);
          end
          2: begin e_cke = 1; e_se = 0; end
          default: begin
            fire = RSP_READY;
            e_se = 1; e_cke = fire; e_rv = fire;
          end
        endcase
        if (e_rv) e_rb = (m_r < stim_q.size()) ? ~stim_q[m_r] : 1'bx;
      end else if (m_mode == 2) begin
        e_busy = 1; e_done = 1;
      end
`ifdef SCAN_MISR_EN
      e_sig = m_sig;
`else
      e_sig = 32'h0;
`endif
      chk("PAT_READY", 32'(PAT_READY), 32'(e_pr));
      chk("RSP_VALID", 32'(RSP_VALID), 32'(e_rv));
      chk("RSP_BIT",   32'(RSP_BIT),   32'(e_rb));
      chk("CKE",       32'(CKE),       32'(e_cke));
      chk("SI",        32'(SI),        32'(e_si));
      chk("SE",        32'(SE),        32'(e_se));
      chk("BUSY",      32'(BUSY),      32'(e_busy));
      chk("DONE",      32'(DONE),      32'(e_done));
      chk("SIGNATURE", SIGNATURE,      e_sig);

      if (RST) begin
        m_mode = 0; m_sig = '0; stim_q.delete();
      end else begin
        case (m_mode)
          0: if (START) begin
            m_sig = '0; stim_q.delete();
            m_c = 0; m_s = 0; m_r = 0;
            if (PAT_CNT == 0) m_mode = 2;
            else begin m_mode = 1; m_p = int'(PAT_CNT); end
          end
          1: begin
            if (ph == 1 && fire) begin stim_q.push_back(PAT_BIT); m_s++; end
            if (ph == 2) m_c++;
            if (e_rv) begin m_sig = misr_ref(m_sig, e_rb); m_r++; end
            if (ph == 3 && m_r == CL * m_p) m_mode = 2;
          end
          default: m_mode = 0;
        endcase
      end
    end
  end

  task automatic run_session(input int p, input int vpct, input int rpct, input int stall,
                             input logic dir, input logic [3:0] dbits,
                             output int done_cyc, output int n_stim, output int n_rsp,
                             output int n_cap, output int n_cke, output int busy_lo,
                             output logic [31:0] obs);
    bit got;
    int k;
    got = 0; done_cyc = -1; n_stim = 0; n_rsp = 0; n_cap = 0; n_cke = 0; busy_lo = 0; obs = '0;
    @(posedge CK); #1;
    START = 1; PAT_CNT = 16'(p); PAT_VALID = 0; RSP_READY = 0;
    for (int cyc = 1; cyc <= 400 && !got; cyc++) begin
      @(posedge CK); #1;
      START     = ($urandom_range(0, 7) == 0);
      PAT_CNT   = 16'($urandom_range(0, 5));
      PAT_VALID = ($urandom_range(1, 100) <= vpct);
      RSP_READY = ($urandom_range(1, 100) <= rpct);
      if (stall != 0 && cyc >= 2 && cyc <= 4)      PAT_VALID = 0;
      if (stall != 0 && (cyc == 10 || cyc == 11)) RSP_READY = 0;
      k = n_stim % 4;
      PAT_BIT = dir ? dbits[3 - k] : 1'($urandom_range(0, 1));
      @(negedge CK);
      if (PAT_READY === 1'b1 && PAT_VALID) n_stim++;
      if (RSP_VALID === 1'b1 && RSP_READY) begin n_rsp++; obs = {obs[30:0], RSP_BIT}; end
      if (CKE === 1'b1) n_cke++;
      if (CKE === 1'b1 && SE === 1'b0) n_cap++;
      if (BUSY !== 1'b1) busy_lo++;
      if (DONE === 1'b1) begin
        got = 1; done_cyc = cyc; START = 0; PAT_VALID = 0; RSP_READY = 0;
      end
    end
    if (!got) chk("session_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int d, ns, nr, nc, nk, bl, cnt;
    logic [31:0] ob;
    RST = 1; START = 0; PAT_CNT = '0; PAT_VALID = 0; PAT_BIT = 0; RSP_READY = 0;
    repeat (2) @(posedge CK);
    #1 model_en = 1;
    @(posedge CK); #1 RST = 0;
    @(negedge CK);
    chk("reset_outputs", {SE, CKE, SI, PAT_READY, RSP_VALID, RSP_BIT, BUSY, DONE}, 32'h0);
    chk("reset_signature", SIGNATURE, 32'h0);

    // P=1, stimulus 1011: response is the inverted load in shift order.
    run_session(1, 100, 100, 0, 1'b1, 4'b1011, d, ns, nr, nc, nk, bl, ob);
    chk("p1_done_cycle", 32'(d), 32'd10);
    chk("p1_stim", 32'(ns), 32'd4);
    chk("p1_rsp_bits", ob, 32'b0100);
    chk("p1_captures", 32'(nc), 32'd1);

    // P=3, always ready.
    run_session(3, 100, 100, 0, 1'b0, 4'b0, d, ns, nr, nc, nk, bl, ob);
    chk("p3_stim", 32'(ns), 32'd12);
    chk("p3_rsp", 32'(nr), 32'd12);
    chk("p3_captures", 32'(nc), 32'd3);
    chk("p3_busy_low", 32'(bl), 32'd0);
    chk("p3_done_cycle", 32'(d), 32'd20);

    // Stalls mid-LOAD and mid-UNLOAD.
    run_session(1, 100, 100, 1, 1'b1, 4'b0110, d, ns, nr, nc, nk, bl, ob);
    chk("stall_done_cycle", 32'(d), 32'd15);
    chk("stall_cke_cnt", 32'(nk), 32'd9);
    chk("stall_rsp_bits", ob, 32'b1001);
    chk("stall_rsp", 32'(nr), 32'd4);

    // Empty session.
    run_session(0, 100, 100, 0, 1'b0, 4'b0, d, ns, nr, nc, nk, bl, ob);
    chk("p0_done_cycle", 32'(d), 32'd1);
    chk("p0_cke_cnt", 32'(nk), 32'd0);

    // Randomised sessions with back-pressure and stray START pulses.
    for (int i = 0; i < 6; i++) begin
      int p;
      p = int'($urandom_range(1, 4));
      run_session(p, 60, 60, 0, 1'b0, 4'b0, d, ns, nr, nc, nk, bl, ob);
      chk("rand_stim", 32'(ns), 32'(p * CL));
      chk("rand_rsp", 32'(nr), 32'(p * CL));
      chk("rand_captures", 32'(nc), 32'(p));
    end

    // Reset in the middle of SHIFT, then a clean session.
    @(posedge CK); #1;
    START = 1; PAT_CNT = 16'd3; PAT_VALID = 1; RSP_READY = 1; PAT_BIT = 1;
    @(posedge CK); #1 START = 0;
    cnt = 0;
    for (int c = 0; c < 50 && cnt < 6; c++) begin
      @(negedge CK);
      if (PAT_READY === 1'b1) cnt++;
    end
    chk("rst_reach_shift", 32'(cnt), 32'd6);
    @(posedge CK); #1 RST = 1;
    @(posedge CK); #1 RST = 0;
    @(negedge CK);
    chk("rst_mid_outputs", {SE, CKE, SI, PAT_READY, RSP_VALID, RSP_BIT, BUSY, DONE}, 32'h0);
    chk("rst_mid_signature", SIGNATURE, 32'h0);
    PAT_VALID = 0; RSP_READY = 0;
    repeat (3) @(negedge CK);
    run_session(2, 80, 80, 0, 1'b0, 4'b0, d, ns, nr, nc, nk, bl, ob);
    chk("post_rst_rsp", 32'(nr), 32'd8);

    // All-zero stimulus yields an all-ones response for the signature check.
    run_session(1, 100, 100, 0, 1'b1, 4'b0000, d, ns, nr, nc, nk, bl, ob);
    chk("ones_rsp_bits", ob, 32'b1111);
    @(negedge CK);
`ifdef SCAN_MISR_EN
    chk("misr_signature", SIGNATURE, 32'h03C0_002D);
`else
    chk("misr_signature", SIGNATURE, 32'h0);
`endif

    repeat (3) @(negedge CK);
    model_en = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
